// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter plus UART transmitter that shares one
// TX line and one baud tick among NUM_REQ byte requesters.
// Each frame is 8N1 and sent LSB first.
// Optional macro UART_TX_SCHED_PARITY_EN inserts an even-parity bit between the
// data bits and the stop bit, which makes the frame 8E1.
//
// state  | meaning
// IDLE   | line high, waiting for any request
// ARMED  | byte captured, waiting for the tick that launches the start bit
// START  | start bit on the line
// DATA   | data bit bit_cnt on the line
// PARITY | even parity bit on the line (parity build only)
// STOP   | stop bit on the line; the closing tick may chain straight into the next start bit

module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 frame_done
);

`ifdef UART_TX_SCHED_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd4,
        PARITY = 3'd5
    } state_t;
    logic parity_bit;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;
`endif

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;

    logic            hi_found;
    logic            lo_found;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;
    logic [ID_W-1:0] arb_idx;
    logic [ID_W-1:0] ptr_nxt;
    logic            arb_en;
    logic            grant;
    logic [7:0]      arb_byte;

    // Round-robin search.
    // Prefer the lowest valid index at or above the pointer; otherwise wrap
    // around to the lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !hi_found && (ID_W'(i) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
            if (req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
        end
    end

    assign arb_idx = hi_found ? hi_idx : lo_idx;
    assign ptr_nxt = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

    // Arbitration happens only in IDLE or on the closing tick of STOP.
    // It is also held off while reset is asserted, so no ack can leak out
    // during reset.
    assign arb_en = rst_n && ((state == IDLE) || ((state == STOP) && baud_tick));
    assign grant  = arb_en && lo_found;
    assign busy   = (state != IDLE);

    // One-hot acknowledge and selection of the winner's byte.
    always_comb begin
        req_ready = '0;
        arb_byte  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == ID_W'(i)) begin
                req_ready[i] = grant;
                arb_byte     = req_data[8*i +: 8];
            end
        end
    end

    // Frame sequencer.
    // Captures the winner on a grant and then advances one bit per baud_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            grant_id   <= '0;
            frame_done <= 1'b0;
            rr_ptr     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (grant) begin
                shreg    <= arb_byte;
                grant_id <= arb_idx;
                rr_ptr   <= ptr_nxt;
`ifdef UART_TX_SCHED_PARITY_EN
                parity_bit <= ^arb_byte;
`endif
            end
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (lo_found) state <= ARMED;
                end
                ARMED: begin
                    if (baud_tick) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end else begin
`ifdef UART_TX_SCHED_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_SCHED_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        frame_done <= 1'b1;
                        if (lo_found) begin
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler.
// Each vector row drives (gap) tick-free cycles followed by one tick cycle.
// It then checks the acks seen during the row and the registered outputs
// just after the tick edge. Requesters set through set_pend drop valid once
// they are acked; hold bits stay high continuously.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic        baud_tick;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;
    logic        frame_done;

    uart_tx_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_reset;
        int          gap;
        logic [3:0]  set_pend;
        logic [3:0]  hold;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic        exp_tx;
        logic        exp_busy;
        logic [1:0]  exp_grant;
        logic        exp_done;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] pend;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add_row(input logic rs, input int gap, input logic [3:0] setp, input logic [3:0] hold,
                           input logic [31:0] data, input logic [3:0] rdy, input logic t,
                           input logic b, input logic [1:0] g, input logic d);
        vec_t v;
        v.do_reset  = rs;
        v.gap       = gap;
        v.set_pend  = setp;
        v.hold      = hold;
        v.data      = data;
        v.exp_ready = rdy;
        v.exp_tx    = t;
        v.exp_busy  = b;
        v.exp_grant = g;
        v.exp_done  = d;
        vecs.push_back(v);
    endtask

    // Expected rows from the first data bit through the closing STOP tick.
    task automatic add_frame(input logic [31:0] data, input logic [1:0] gid, input int gap,
                             input logic [3:0] hold, input int inj_at, input logic [3:0] inj_mask,
                             input logic [3:0] end_ready, input logic [1:0] end_gid,
                             input logic end_tx, input logic end_busy);
        logic [31:0] sh;
        logic [7:0]  b;
        sh = data >> (8 * int'(gid));
        b  = sh[7:0];
        for (int k = 0; k < 8; k++)
            add_row(1'b0, gap, (k == inj_at) ? inj_mask : 4'b0000, hold, data, 4'b0000, b[k], 1'b1, gid, 1'b0);
`ifdef UART_TX_SCHED_PARITY_EN
        add_row(1'b0, gap, 4'b0000, hold, data, 4'b0000, ^b, 1'b1, gid, 1'b0);
`endif
        add_row(1'b0, gap, 4'b0000, hold, data, 4'b0000, 1'b1, 1'b1, gid, 1'b0);
        add_row(1'b0, gap, 4'b0000, hold, data, end_ready, end_tx, end_busy, end_gid, 1'b1);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        baud_tick = 1'b0;
        req_valid = '0;
        pend      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t v, input int r);
        logic [3:0] seen;
        logic [3:0] rdy;
        if (v.do_reset) apply_reset();
        pend = pend | v.set_pend;
        seen = '0;
        for (int c = 0; c <= v.gap; c++) begin
            req_valid = pend | v.hold;
            req_data  = v.data;
            baud_tick = (c == v.gap);
            #1;
            rdy  = req_ready;
            seen = seen | rdy;
            @(posedge clk);
            #1;
            pend = pend & ~rdy;
        end
        baud_tick = 1'b0;
        chk("req_ready", r, 32'(seen), 32'(v.exp_ready));
        chk("tx", r, 32'(tx), 32'(v.exp_tx));
        chk("busy", r, 32'(busy), 32'(v.exp_busy));
        chk("grant_id", r, 32'(grant_id), 32'(v.exp_grant));
        chk("frame_done", r, 32'(frame_done), 32'(v.exp_done));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        pend      = '0;
        rst_n     = 1'b0;
        baud_tick = 1'b0;
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;

        // Reset state; a valid request must not be acked while reset is held.
        #12;
        chk("rst_tx", -1, 32'(tx), 32'd1);
        chk("rst_busy", -1, 32'(busy), 32'd0);
        chk("rst_ready", -1, 32'(req_ready), 32'd0);
        chk("rst_grant", -1, 32'(grant_id), 32'd0);
        chk("rst_done", -1, 32'(frame_done), 32'd0);

`ifdef UART_TX_SCHED_PARITY_EN
        // 8E1 frame for 0x07: the parity bit is 1, and done follows the 11th tick.
        add_row(1'b1, 0, 4'b0001, 4'b0000, 32'h0000_0007, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        add_row(1'b0, 0, 4'b0000, 4'b0000, 32'h0000_0007, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
        add_frame(32'h0000_0007, 2'd0, 0, 4'b0000, -1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
`endif

        // Single 0xA5 frame with a tick every 4 cycles.
        add_row(1'b1, 3, 4'b0001, 4'b0000, 32'h0000_00A5, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
        add_frame(32'h0000_00A5, 2'd0, 3, 4'b0000, -1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        add_row(1'b0, 3, 4'b0000, 4'b0000, 32'h0000_00A5, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);

        // All four requesters hold valid: grants go 0,1,2,3,0 back-to-back
        // with baud_tick held high.
        add_row(1'b1, 0, 4'b0000, 4'b1111, 32'h4433_2211, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        add_row(1'b0, 0, 4'b0000, 4'b1111, 32'h4433_2211, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
        add_frame(32'h4433_2211, 2'd0, 0, 4'b1111, -1, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1);
        add_frame(32'h4433_2211, 2'd1, 0, 4'b1111, -1, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b1);
        add_frame(32'h4433_2211, 2'd2, 0, 4'b1111, -1, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1);
        add_frame(32'h4433_2211, 2'd3, 0, 4'b1111, -1, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1);

        // Requester 2 raises valid during DATA; its ack and start bit land on the STOP tick.
        add_row(1'b1, 1, 4'b0001, 4'b0000, 32'h00C3_005A, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
        add_frame(32'h00C3_005A, 2'd0, 1, 4'b0000, 2, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1);
        add_frame(32'h00C3_005A, 2'd2, 1, 4'b0000, -1, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);

        // One-cycle valid[1] coincident with a tick in IDLE.
        // The ack comes at once, and the start bit waits for the next tick.
        add_row(1'b0, 0, 4'b0010, 4'b0000, 32'h0000_9600, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
        add_row(1'b0, 3, 4'b0000, 4'b0000, 32'h0000_9600, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);
        // 0x96 bits 0..3 = 0,1,1,0
        add_row(1'b0, 3, 4'b0000, 4'b0000, 32'h0000_9600, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);
        add_row(1'b0, 3, 4'b0000, 4'b0000, 32'h0000_9600, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0);
        add_row(1'b0, 3, 4'b0000, 4'b0000, 32'h0000_9600, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0);
        add_row(1'b0, 3, 4'b0000, 4'b0000, 32'h0000_9600, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);

        for (int r = 0; r < vecs.size(); r++)
            run_row(vecs[r], r);

        // Reset mid-frame during data bit 3.
        // tx and busy must recover immediately, and requester 3 is granted after release.
        baud_tick = 1'b0;
        req_valid = 4'b1000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_tx", -2, 32'(tx), 32'd1);
        chk("abort_busy", -2, 32'(busy), 32'd0);
        chk("abort_ready", -2, 32'(req_ready), 32'd0);
        chk("abort_grant", -2, 32'(grant_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", -2, 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        chk("post_rst_grant", -2, 32'(grant_id), 32'd3);
        chk("post_rst_busy", -2, 32'(busy), 32'd1);
        chk("post_rst_tx", -2, 32'(tx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
